// File: rtl/dualshock_device.sv
// Device-side DualShock/PSX pad responder: oversamples host CLK/SEL/CMD, returns ID, button and
// analog bytes on DAT with delayed ACK pulses, and captures the host's motor bytes.
module dualshock_device #(
  parameter int unsigned ACK_DELAY   = 40,
  parameter int unsigned ACK_WIDTH   = 100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps_clk,
  input  logic        ps_sel,
  input  logic        ps_cmd,
  output logic        ps_dat,
  output logic        ps_ack_n,
  input  logic        analog_mode,
  input  logic [15:0] buttons_n,
  input  logic [7:0]  axis_rx,
  input  logic [7:0]  axis_ry,
  input  logic [7:0]  axis_lx,
  input  logic [7:0]  axis_ly,
  output logic [7:0]  vib_small,
  output logic [7:0]  vib_large,
  output logic        vib_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {StIdle, StActive, StHalt} state_e;
  typedef enum logic [1:0] {AckIdle, AckWait, AckLow} ack_e;

  localparam logic [15:0] DelayM1 = 16'(ACK_DELAY - 1);
  localparam logic [15:0] WidthM1 = 16'(ACK_WIDTH - 1);

  logic [SYNC_STAGES-1:0] r_sync_clk, r_sync_sel, r_sync_cmd;
  logic                   r_clk_prev, r_sel_prev;
  logic                   w_clk, w_sel, w_cmd;
  logic                   w_clk_rise, w_clk_fall, w_sel_fall;

  state_e      r_state;
  ack_e        r_ack;
  logic [15:0] r_ack_cnt;
  logic [3:0]  r_byte_idx;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx, r_tx;
  logic        r_analog;
  logic [15:0] r_btn;
  logic [7:0]  r_ax_rx, r_ax_ry, r_ax_lx, r_ax_ly;
  logic [7:0]  r_pend_small, r_pend_large;

  logic [3:0]  w_idx_next, w_last;
  logic [7:0]  w_rx_next, w_next_tx;
  logic        w_bad_hdr;

  // Host lines idle high, so synchronizers reset high to avoid a false sel fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_clk <= '1;
      r_sync_sel <= '1;
      r_sync_cmd <= '1;
      r_clk_prev <= 1'b1;
      r_sel_prev <= 1'b1;
    end else begin
      r_sync_clk <= {r_sync_clk[SYNC_STAGES-2:0], ps_clk};
      r_sync_sel <= {r_sync_sel[SYNC_STAGES-2:0], ps_sel};
      r_sync_cmd <= {r_sync_cmd[SYNC_STAGES-2:0], ps_cmd};
      r_clk_prev <= w_clk;
      r_sel_prev <= w_sel;
    end
  end

  assign w_clk      = r_sync_clk[SYNC_STAGES-1];
  assign w_sel      = r_sync_sel[SYNC_STAGES-1];
  assign w_cmd      = r_sync_cmd[SYNC_STAGES-1];
  assign w_clk_rise = w_clk & ~r_clk_prev;
  assign w_clk_fall = ~w_clk & r_clk_prev;
  assign w_sel_fall = ~w_sel & r_sel_prev;

  assign w_idx_next = r_byte_idx + 4'd1;
  assign w_last     = r_analog ? 4'd8 : 4'd4;
  assign w_rx_next  = {w_cmd, r_rx[7:1]};
  assign w_bad_hdr  = ((r_byte_idx == 4'd0) && (w_rx_next != 8'h01)) ||
                      ((r_byte_idx == 4'd1) && (w_rx_next != 8'h42));

  always_comb begin
    w_next_tx = 8'hFF;
    case (w_idx_next)
      4'd1:    w_next_tx = r_analog ? 8'h73 : 8'h41;
      4'd2:    w_next_tx = 8'h5A;
      4'd3:    w_next_tx = r_btn[7:0];
      4'd4:    w_next_tx = r_btn[15:8];
      4'd5:    w_next_tx = r_ax_rx;
      4'd6:    w_next_tx = r_ax_ry;
      4'd7:    w_next_tx = r_ax_lx;
      4'd8:    w_next_tx = r_ax_ly;
      default: w_next_tx = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_ack        <= AckIdle;
      r_ack_cnt    <= '0;
      r_byte_idx   <= '0;
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_tx         <= 8'hFF;
      r_analog     <= 1'b0;
      r_btn        <= '1;
      r_ax_rx      <= '0;
      r_ax_ry      <= '0;
      r_ax_lx      <= '0;
      r_ax_ly      <= '0;
      r_pend_small <= '0;
      r_pend_large <= '0;
      ps_dat       <= 1'b1;
      ps_ack_n     <= 1'b1;
      vib_small    <= '0;
      vib_large    <= '0;
      vib_valid    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      vib_valid  <= 1'b0;
      frame_done <= 1'b0;

      // ACK sequencer runs independently of the shift logic.
      case (r_ack)
        AckWait: begin
          if (r_ack_cnt == '0) begin
            r_ack     <= AckLow;
            ps_ack_n  <= 1'b0;
            r_ack_cnt <= WidthM1;
          end else begin
            r_ack_cnt <= r_ack_cnt - 16'd1;
          end
        end
        AckLow: begin
          if (r_ack_cnt == '0) begin
            r_ack    <= AckIdle;
            ps_ack_n <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt - 16'd1;
          end
        end
        default: ;
      endcase

      if (w_sel) begin
        r_state    <= StIdle;
        r_ack      <= AckIdle;
        r_ack_cnt  <= '0;
        r_byte_idx <= '0;
        r_bit_cnt  <= '0;
        ps_dat     <= 1'b1;
        ps_ack_n   <= 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_sel_fall) begin
              r_state      <= StActive;
              r_analog     <= analog_mode;
              r_btn        <= buttons_n;
              r_ax_rx      <= axis_rx;
              r_ax_ry      <= axis_ry;
              r_ax_lx      <= axis_lx;
              r_ax_ly      <= axis_ly;
              r_pend_small <= '0;
              r_pend_large <= '0;
              r_byte_idx   <= '0;
              r_bit_cnt    <= '0;
              r_tx         <= 8'hFF;
              ps_dat       <= 1'b1;
            end
          end
          StActive: begin
            if (w_clk_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_byte_idx == 4'd3) r_pend_small <= w_rx_next;
                if (r_byte_idx == 4'd4) r_pend_large <= w_rx_next;
                if (w_bad_hdr) begin
                  r_state <= StHalt;
                  ps_dat  <= 1'b1;
                end else if (r_byte_idx == w_last) begin
                  r_state    <= StHalt;
                  ps_dat     <= 1'b1;
                  frame_done <= 1'b1;
                  vib_valid  <= 1'b1;
                  vib_small  <= r_pend_small;
                  // In digital mode byte 4 is also the last byte.
                  vib_large  <= (r_byte_idx == 4'd4) ? w_rx_next : r_pend_large;
                end else begin
                  r_byte_idx <= w_idx_next;
                  r_tx       <= w_next_tx;
                  ps_dat     <= w_next_tx[0];
                  r_ack      <= AckWait;
                  r_ack_cnt  <= DelayM1;
                end
              end
            end else if (w_clk_fall && (r_bit_cnt != 3'd0)) begin
              ps_dat <= r_tx[r_bit_cnt];
            end
          end
          StHalt: ps_dat <= 1'b1;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule
